// File: rtl/vid_pkg.sv
// Shared definitions for the video pattern source: pattern codes, colour-bar
// palette and the timing total helper.
package vid_pkg;

    typedef logic [1:0] pat_t;

    localparam pat_t PAT_SOLID = 2'd0;
    localparam pat_t PAT_BARS  = 2'd1;
    localparam pat_t PAT_GRAD  = 2'd2;
    localparam pat_t PAT_CHECK = 2'd3;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Total period of one axis from its four region widths.
    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Colour of bar number idx, left to right.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = BAR_WHITE;
            3'd1:    rgb = BAR_YELLOW;
            3'd2:    rgb = BAR_CYAN;
            3'd3:    rgb = BAR_GREEN;
            3'd4:    rgb = BAR_MAGENTA;
            3'd5:    rgb = BAR_RED;
            3'd6:    rgb = BAR_BLUE;
            default: rgb = BAR_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/video_pattern_src_if.sv
// Registered video stream produced by the pattern source: DE, syncs, RGB and
// the start-of-frame marker.
interface video_pattern_src_if;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [23:0] pixel_out;
    logic        frame_start;

    modport master (
        output de_out,
        output h_sync_out,
        output v_sync_out,
        output pixel_out,
        output frame_start
    );

    modport slave (
        input de_out,
        input h_sync_out,
        input v_sync_out,
        input pixel_out,
        input frame_start
    );
endinterface

// File: rtl/video_timing_counter.sv
// Raster position counters plus the unregistered region decodes of the
// current position.
module video_timing_counter
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          h_act_o,
    output logic          v_act_o,
    output logic          hs_act_o,
    output logic          vs_act_o,
    output logic          sof_o,
    output logic          h_last_o
);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_last;
    logic          v_last;

    assign h_last = (int'(h_cnt_q) == H_TOTAL - 1);
    assign v_last = (int'(v_cnt_q) == V_TOTAL - 1);

    // Next raster position: h wraps each line, v steps on the h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Position registers advance only on enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (en_i) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o  = h_cnt_q;
    assign v_cnt_o  = v_cnt_q;
    assign h_last_o = h_last;
    assign h_act_o  = (int'(h_cnt_q) < H_ACTIVE);
    assign v_act_o  = (int'(v_cnt_q) < V_ACTIVE);
    assign hs_act_o = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                      (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    // v_cnt only moves on the h wrap, so vsync edges land at line start.
    assign vs_act_o = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                      (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
    assign sof_o    = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/video_pattern_src.sv
// Test-pattern video source: raster timing, frame-synchronous pattern select,
// colour-bar counters, pixel mux and the registered output stage.
module video_pattern_src
    import vid_pkg::*;
#(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter logic [23:0] SOLID_RGB = 24'h0000FF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 pattern_sel,
    video_pattern_src_if.master        vo
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_act, v_act, hs_act, vs_act, sof, h_last;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en),
        .h_cnt_o  (h_cnt),
        .v_cnt_o  (v_cnt),
        .h_act_o  (h_act),
        .v_act_o  (v_act),
        .hs_act_o (hs_act),
        .vs_act_o (vs_act),
        .sof_o    (sof),
        .h_last_o (h_last)
    );

    pat_t          pat_q;
    pat_t          cur_pat;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [23:0]   pix_d;
    logic [7:0]    x_lo;
    logic          x_b4, y_b4;

    logic          de_q, hs_q, vs_q, fs_q;
    logic [23:0]   pix_q;

    // The pixel at (0,0) already uses the newly selected pattern.
    assign cur_pat = sof ? pattern_sel : pat_q;
    assign x_lo    = 8'(h_cnt);
    assign x_b4    = 1'(int'(h_cnt) >> 4);
    assign y_b4    = 1'(int'(v_cnt) >> 4);

    // Pattern changes only at frame start so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= PAT_SOLID;
        end else if (en && sof) begin
            pat_q <= pattern_sel;
        end
    end

    // Bar position: width counter rolls into a bar index, both zero at x=0.
    always_comb begin
        bar_cnt_d = bar_cnt_q + BW'(1);
        bar_idx_d = bar_idx_q;
        if (h_last) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (int'(bar_cnt_q) == BAR_W - 1) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end
    end

    // Bar counters follow h_cnt on enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else if (en) begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Pixel colour for the current position; black outside the active area.
    always_comb begin
        pix_d = '0;
        if (h_act && v_act) begin
            case (cur_pat)
                PAT_SOLID: pix_d = SOLID_RGB;
                PAT_BARS:  pix_d = bar_rgb(bar_idx_q);
                PAT_GRAD:  pix_d = {x_lo, x_lo, x_lo};
                PAT_CHECK: pix_d = (x_b4 ^ y_b4) ? 24'hFFFFFF : 24'h000000;
                default:   pix_d = '0;
            endcase
        end
    end

    // Output stage: one cycle behind the counters, frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            pix_q <= '0;
            fs_q  <= 1'b0;
        end else if (en) begin
            de_q  <= h_act && v_act;
            hs_q  <= hs_act ? HS_POL : ~HS_POL;
            vs_q  <= vs_act ? VS_POL : ~VS_POL;
            pix_q <= pix_d;
            fs_q  <= sof;
        end else begin
            fs_q  <= 1'b0;
        end
    end

    assign vo.de_out      = de_q;
    assign vo.h_sync_out  = hs_q;
    assign vo.v_sync_out  = vs_q;
    assign vo.pixel_out   = pix_q;
    assign vo.frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_src.sv
// Bench for video_pattern_src on a tiny 24x8 raster: a position/pattern model
// checked every cycle, plus directed literal checks.
module tb_video_pattern_src;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [1:0] sel = 2'd0;

    int checks = 0;
    int errors = 0;

    video_pattern_src_if vif ();

    video_pattern_src #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL (1'b0), .VS_POL (1'b0), .SOLID_RGB (24'h0000FF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (sel),
        .vo          (vif.master)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    bit          mvalid = 1'b0;
    int          mx = 0, my = 0;
    logic [1:0]  mpat = 2'd0;
    logic        exp_de = 1'b0, exp_hs = 1'b1, exp_vs = 1'b1, exp_fs = 1'b0;
    logic [23:0] exp_pix = 24'h0;

    function automatic logic [23:0] model_pixel(input int x, input int y,
                                                input logic [1:0] p);
        logic [7:0] g;
        if (!(x < HA && y < VA)) return 24'h0;
        case (p)
            2'd0: return 24'h0000FF;
            2'd1: return bar_tab[x / (HA / 8)];
            2'd2: begin g = x[7:0]; return {g, g, g}; end
            default: return ((((x / 16) ^ (y / 16)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mvalid  = 1'b1;
            mx = 0; my = 0; mpat = 2'd0;
            exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0;
            exp_pix = 24'h0;
        end else if (en && mvalid) begin
            if (mx == 0 && my == 0) mpat = sel;
            exp_de  = (mx < HA) && (my < VA);
            exp_hs  = !((mx >= HA + HF) && (mx < HA + HF + HS));
            exp_vs  = !((my >= VA + VF) && (my < VA + VF + VS));
            exp_fs  = (mx == 0) && (my == 0);
            exp_pix = model_pixel(mx, my, mpat);
            mx = mx + 1;
            if (mx == HT) begin
                mx = 0;
                my = (my + 1) % VT;
            end
        end else if (!en) begin
            exp_fs = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if (vif.de_out !== exp_de || vif.h_sync_out !== exp_hs ||
                vif.v_sync_out !== exp_vs || vif.frame_start !== exp_fs ||
                vif.pixel_out !== exp_pix) begin
                errors++;
                $display("FAIL cycle_model t=%0t got de=%0b hs=%0b vs=%0b fs=%0b pix=%06h want de=%0b hs=%0b vs=%0b fs=%0b pix=%06h",
                         $time, vif.de_out, vif.h_sync_out, vif.v_sync_out,
                         vif.frame_start, vif.pixel_out, exp_de, exp_hs,
                         exp_vs, exp_fs, exp_pix);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end else begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    logic [23:0] line0_exp [24] = '{
        24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h00FFFF, 24'h00FFFF,
        24'h00FF00, 24'h00FF00, 24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
        24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000,
        24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int de_mask, hs_mask, vs_lo, vs_first, de_blank;
        int fs_cnt, fs_last, gap_bad, n;
        logic [23:0] snap_pix;
        logic        snap_de, snap_hs, snap_vs;

        // Test 1/2: reset state, solid pattern, two frames of timing.
        rst = 1'b1; en = 1'b1; sel = 2'd0;
        step(2);
        chk("reset_de", int'(vif.de_out), 0);
        chk("reset_hs", int'(vif.h_sync_out), 1);
        chk("reset_vs", int'(vif.v_sync_out), 1);
        chk("reset_pix", int'(vif.pixel_out), 0);
        chk("reset_fs", int'(vif.frame_start), 0);
        rst = 1'b0;
        step(1);
        chk("first_fs", int'(vif.frame_start), 1);
        chk("first_de", int'(vif.de_out), 1);
        chk("first_pix", int'(vif.pixel_out), 24'h0000FF);

        de_mask = 0; hs_mask = 0; vs_lo = 0; vs_first = -1; de_blank = 0;
        fs_cnt = 0; fs_last = -1; gap_bad = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (i < HT && vif.de_out) de_mask |= (1 << i);
            if (i < HT && !vif.h_sync_out) hs_mask |= (1 << i);
            if (i < HT * VT && !vif.v_sync_out) begin
                vs_lo++;
                if (vs_first < 0) vs_first = i;
            end
            if (((i / HT) % VT) >= VA && vif.de_out) de_blank++;
            if (vif.frame_start) begin
                if (fs_last >= 0 && (i - fs_last) != HT * VT) gap_bad++;
                fs_last = i;
                fs_cnt++;
            end
            step(1);
        end
        chk("line0_de_mask", de_mask, 32'h00FFFF);
        chk("line0_hs_mask", hs_mask, 32'h1C0000);
        chk("vsync_low_cycles", vs_lo, 48);
        chk("vsync_first_cycle", vs_first, 120);
        chk("de_in_vblank", de_blank, 0);
        chk("frame_start_count", fs_cnt, 2);
        chk("frame_start_gap_bad", gap_bad, 0);
        chk("frame_start_last", fs_last, 192);

        // Test 3: colour bars from reset.
        rst = 1'b1; sel = 2'd1;
        step(2);
        rst = 1'b0;
        step(1);
        for (int x = 0; x < HT; x++) begin
            chk($sformatf("bars_x%0d", x), int'(vif.pixel_out), int'(line0_exp[x]));
            step(1);
        end

        // Test 4: switch solid -> gradient mid-frame.
        rst = 1'b1; sel = 2'd0;
        step(2);
        rst = 1'b0;
        step(1);
        step(48);
        sel = 2'd2;
        step(29);
        chk("no_tear_line3_x5", int'(vif.pixel_out), 24'h0000FF);
        step(115);
        for (int x = 0; x < HA; x++) begin
            chk($sformatf("grad_x%0d", x), int'(vif.pixel_out), x * 24'h010101);
            step(1);
        end

        // Test 5: en low for 5 cycles at line 1, x=7.
        step(15);
        chk("pre_freeze_pix", int'(vif.pixel_out), 24'h070707);
        snap_pix = vif.pixel_out; snap_de = vif.de_out;
        snap_hs = vif.h_sync_out; snap_vs = vif.v_sync_out;
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk($sformatf("freeze_pix_%0d", k), int'(vif.pixel_out), int'(snap_pix));
            chk($sformatf("freeze_ctl_%0d", k),
                int'({vif.de_out, vif.h_sync_out, vif.v_sync_out, vif.frame_start}),
                int'({snap_de, snap_hs, snap_vs, 1'b0}));
        end
        en = 1'b1;
        n = 0;
        while (vif.h_sync_out && n < 40) begin step(1); n++; end
        chk("steps_x7_to_hsync", n, 11);
        n = 0;
        while (!vif.de_out && n < 40) begin step(1); n++; end
        chk("steps_hsync_to_de", n, 6);

        // Test 6: reset pulse at line 2, x=9.
        step(9);
        rst = 1'b1;
        step(1);
        chk("midrst_de", int'(vif.de_out), 0);
        chk("midrst_pix", int'(vif.pixel_out), 0);
        chk("midrst_syncs", int'({vif.h_sync_out, vif.v_sync_out}), 3);
        rst = 1'b0;
        step(1);
        chk("restart_fs", int'(vif.frame_start), 1);
        chk("restart_de", int'(vif.de_out), 1);
        step(3);
        chk("restart_pix_x3", int'(vif.pixel_out), 24'h030303);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
